// File: rtl/spi_burst_engine.sv
// spi_burst_engine
//   Burst sequencer sitting in front of a byte-wide SPI controller. Software
//   queues bytes in a TX FIFO, requests a burst of i_len bytes, and the engine
//   configures the controller once, frames the burst with chip select, streams
//   the bytes out one at a time and collects each returned byte into an RX FIFO.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cfg_mode/ratio      SPI mode and sclk divide ratio captured at start
//   i_len, i_start        burst length (1..16) and one-cycle burst request
//   i_tx_data/i_tx_wr     TX FIFO write port, o_tx_full
//   o_rx_data/o_rx_empty  RX FIFO head (first-word-fall-through), i_rx_rd pops
//   o_busy/o_done/o_err   status: burst active, completion pulse, reject pulse
//   o_cs_n                active-low chip select
//   o_ctl_*/i_ctl_*       controller side: config word, byte request, ready,
//                         received byte
module spi_burst_engine #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_cfg_mode,
  input  logic [7:0]  i_cfg_ratio,
  input  logic [4:0]  i_len,
  input  logic        i_start,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_wr,
  output logic        o_tx_full,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_empty,
  input  logic        i_rx_rd,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cs_n,
  output logic [10:0] o_ctl_config,
  output logic [7:0]  o_ctl_tx,
  output logic        o_ctl_tx_valid,
  input  logic        i_ctl_ready,
  input  logic [7:0]  i_ctl_rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CFG, CFG_WAIT, CS_SETUP, LOAD, XFER_WAIT, CS_HOLD, FINISH
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  len_left_reg, len_left_next;
  logic [1:0]  mode_reg, mode_next;
  logic [7:0]  ratio_reg, ratio_next;
  logic        hold_cnt_reg, hold_cnt_next;   // counts the two CS setup/hold cycles
  logic        err_reg, err_next;
  logic [7:0]  tx_byte_reg;

  // FIFO storage and bookkeeping
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0] tx_count_reg, rx_count_reg;
  logic [7:0]    rx_last_reg;                 // shown on o_rx_data while RX is empty

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_full, rx_empty;
  logic start_ok, cs_active, cfg_drive, tx_valid;

  assign tx_full  = (tx_count_reg == DEPTH_C);
  assign rx_empty = (rx_count_reg == '0);

  // A push into a full TX FIFO is only taken when the engine frees a slot
  // in the same cycle, so simultaneous push/pop at full keeps the count.
  assign tx_push = i_tx_wr && (!tx_full || tx_pop);
  assign rx_pop  = i_rx_rd && !rx_empty;

  assign start_ok = (i_len != 5'd0) && (i_len <= 5'd16)
                 && (8'(tx_count_reg) >= {3'b000, i_len})
                 && (8'(DEPTH_C - rx_count_reg) >= {3'b000, i_len});

  always_comb begin
    state_next    = state_reg;
    len_left_next = len_left_reg;
    mode_next     = mode_reg;
    ratio_next    = ratio_reg;
    hold_cnt_next = hold_cnt_reg;
    err_next      = 1'b0;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    cs_active     = 1'b0;
    cfg_drive     = 1'b0;
    tx_valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (start_ok) begin
            state_next    = CFG;
            len_left_next = i_len;
            mode_next     = i_cfg_mode;
            ratio_next    = i_cfg_ratio;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      CFG: begin
        cfg_drive = 1'b1;
        if (!i_ctl_ready) state_next = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (i_ctl_ready) begin
          state_next    = CS_SETUP;
          hold_cnt_next = 1'b0;
        end
      end
      CS_SETUP: begin
        cs_active = 1'b1;
        if (hold_cnt_reg) begin
          state_next = LOAD;
          tx_pop     = 1'b1;       // head byte lands in tx_byte_reg on LOAD entry
        end else begin
          hold_cnt_next = 1'b1;
        end
      end
      LOAD: begin
        cs_active = 1'b1;
        tx_valid  = 1'b1;
        if (!i_ctl_ready) state_next = XFER_WAIT;
      end
      XFER_WAIT: begin
        cs_active = 1'b1;
        if (i_ctl_ready) begin
          rx_push       = 1'b1;
          len_left_next = len_left_reg - 5'd1;
          if (len_left_reg == 5'd1) begin
            state_next    = CS_HOLD;
            hold_cnt_next = 1'b0;
          end else begin
            state_next = LOAD;
            tx_pop     = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        cs_active = 1'b1;
        if (hold_cnt_reg) state_next = FINISH;
        else              hold_cnt_next = 1'b1;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      len_left_reg <= 5'd0;
      mode_reg     <= 2'd0;
      ratio_reg    <= 8'd0;
      hold_cnt_reg <= 1'b0;
      err_reg      <= 1'b0;
      tx_byte_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      len_left_reg <= len_left_next;
      mode_reg     <= mode_next;
      ratio_reg    <= ratio_next;
      hold_cnt_reg <= hold_cnt_next;
      err_reg      <= err_next;
      if (tx_pop) tx_byte_reg <= tx_mem[tx_rd_ptr_reg];
    end
  end

  // FIFO storage has no reset; emptiness is carried by the counts.
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= i_tx_data;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= i_ctl_rx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
      rx_last_reg   <= 8'd0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + AW'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + AW'(1);
      if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + CW'(1);
      else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - CW'(1);

      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + AW'(1);
      if (rx_pop) begin
        rx_rd_ptr_reg <= rx_rd_ptr_reg + AW'(1);
        rx_last_reg   <= rx_mem[rx_rd_ptr_reg];
      end
      if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + CW'(1);
      else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - CW'(1);
    end
  end

  // Outputs decode from the asynchronously reset state, so chip select and
  // the byte request drop in the same cycle a reset is asserted.
  assign o_tx_full      = tx_full;
  assign o_rx_empty     = rx_empty;
  assign o_rx_data      = rx_empty ? rx_last_reg : rx_mem[rx_rd_ptr_reg];
  assign o_busy         = (state_reg != IDLE);
  assign o_done         = (state_reg == FINISH);
  assign o_err          = err_reg;
  assign o_cs_n         = !cs_active;
  assign o_ctl_config   = cfg_drive ? {ratio_reg, mode_reg, 1'b1} : 11'd0;
  assign o_ctl_tx       = tx_byte_reg;
  assign o_ctl_tx_valid = tx_valid;

endmodule

// File: tb/tb_spi_burst_engine.sv
module tb_spi_burst_engine;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_ratio = 8'd0;
  logic [4:0]  len_in = 5'd0;
  logic        start = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_wr = 1'b0;
  logic        tx_full;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rx_rd = 1'b0;
  logic        busy, done, err, cs_n;
  logic [10:0] ctl_config;
  logic [7:0]  ctl_tx;
  logic        ctl_tx_valid;
  logic        ctl_ready;
  logic [7:0]  ctl_rx;

  spi_burst_engine #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_mode(cfg_mode), .i_cfg_ratio(cfg_ratio),
    .i_len(len_in), .i_start(start), .i_tx_data(tx_data), .i_tx_wr(tx_wr),
    .o_tx_full(tx_full), .o_rx_data(rx_data), .o_rx_empty(rx_empty),
    .i_rx_rd(rx_rd), .o_busy(busy), .o_done(done), .o_err(err), .o_cs_n(cs_n),
    .o_ctl_config(ctl_config), .o_ctl_tx(ctl_tx), .o_ctl_tx_valid(ctl_tx_valid),
    .i_ctl_ready(ctl_ready), .i_ctl_rx(ctl_rx)
  );

  always #5 clk = ~clk;

  // ---------------- loopback controller model ----------------
  int          ctl_busy = 0;
  logic [7:0]  cur_ratio = 8'd0;
  logic [10:0] cfg_log[$];
  logic [7:0]  sent_q[$];

  assign ctl_ready = (ctl_busy == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_busy <= 0;
      ctl_rx   <= 8'h00;
    end else if (ctl_busy > 0) begin
      ctl_busy <= ctl_busy - 1;
    end else if (ctl_config[0]) begin
      cfg_log.push_back(ctl_config);
      cur_ratio <= ctl_config[10:3];
      ctl_busy  <= 3;
    end else if (ctl_tx_valid) begin
      sent_q.push_back(ctl_tx);
      ctl_rx   <= ctl_tx;              // copi looped to cipo
      ctl_busy <= 1 + int'(cur_ratio);
    end
  end

  // ---------------- pulse monitors ----------------
  int   done_cnt = 0, err_cnt = 0, cs_rises = 0;
  logic cs_prev = 1'b1;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
    if (cs_n && !cs_prev) cs_rises <= cs_rises + 1;
    cs_prev <= cs_n;
  end

  // ---------------- reference model ----------------
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_popped = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
    check("tx_full", tx_full, tx_q.size() == DEPTH);
    $display("write 0x%02h tx_level=%0d full=%0b", b, tx_q.size(), tx_full);
  endtask

  task automatic pop_rx();
    logic was_empty;
    was_empty = (rx_q.size() == 0);
    if (!was_empty) begin
      check("rx_empty_flag", rx_empty, 1'b0);
      check("rx_data", rx_data, rx_q[0]);
      last_popped = rx_q.pop_front();
    end else begin
      check("rx_empty_idle", rx_empty, 1'b1);
    end
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    if (was_empty) check("rx_hold", rx_data, last_popped);
    $display("pop %s data=0x%02h rx_level=%0d", was_empty ? "empty" : "byte", rx_data, rx_q.size());
  endtask

  task automatic run_burst(input int len, input logic [1:0] mode, input logic [7:0] ratio,
                           input bit mid_start);
    int d0, e0, c0, s0, r0, cyc;
    bit acc;
    logic [7:0] exp_bytes[$];
    d0 = done_cnt; e0 = err_cnt; c0 = cfg_log.size(); s0 = sent_q.size(); r0 = cs_rises;
    acc = (len >= 1) && (len <= 16) && (tx_q.size() >= len) && ((DEPTH - rx_q.size()) >= len);
    len_in = len[4:0]; cfg_mode = mode; cfg_ratio = ratio; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_err", err, !acc);
    check("start_busy", busy, acc);
    if (acc) begin
      for (int i = 0; i < len; i++) begin
        exp_bytes.push_back(tx_q[0]);
        rx_q.push_back(tx_q.pop_front());
      end
      if (mid_start) begin
        repeat (6) @(negedge clk);
        len_in = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("burst_timeout", cyc < 3000, 1'b1);
    @(negedge clk);
    check("done_pulses", done_cnt - d0, acc ? 1 : 0);
    check("err_pulses", err_cnt - e0, acc ? 0 : 1);
    check("cfg_count", cfg_log.size() - c0, acc ? 1 : 0);
    if (acc && cfg_log.size() > c0) check("cfg_word", cfg_log[c0], {ratio, mode, 1'b1});
    check("cs_frames", cs_rises - r0, acc ? 1 : 0);
    check("sent_count", sent_q.size() - s0, acc ? len : 0);
    for (int i = 0; i < exp_bytes.size(); i++)
      if (s0 + i < sent_q.size()) check("sent_byte", sent_q[s0 + i], exp_bytes[i]);
    check("idle_after", busy, 1'b0);
    $display("burst len=%0d mode=%0d ratio=%0d accepted=%0b cycles=%0d", len, mode, ratio, acc, cyc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, cyc, nw, np;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cfg", ctl_config, 11'd0);
    check("rst_ctl_tx", ctl_tx, 8'd0);
    check("rst_tx_valid", ctl_tx_valid, 1'b0);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_data", rx_data, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic three-byte burst
    write_byte(8'hA5); write_byte(8'h3C); write_byte(8'hFF);
    run_burst(3, 2'd0, 8'd2, 1'b0);
    repeat (3) pop_rx();
    pop_rx();

    // rejected start: not enough TX bytes, contents must survive
    write_byte(8'h11); write_byte(8'h22);
    run_burst(4, 2'd0, 8'd1, 1'b0);
    run_burst(2, 2'd3, 8'd1, 1'b0);
    repeat (2) pop_rx();

    // overfill TX with 17 bytes, then full-length burst
    for (int i = 0; i < 17; i++) write_byte(8'h40 + 8'(i));
    run_burst(16, 2'd1, 8'd4, 1'b0);
    for (int i = 0; i < 16; i++) pop_rx();
    check("rx_empty_after16", rx_empty, 1'b1);
    run_burst(1, 2'd0, 8'd0, 1'b0);      // 17th byte must not be there

    // start while busy is ignored
    for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
    run_burst(3, 2'd2, 8'd1, 1'b1);
    repeat (3) pop_rx();

    // reset during the second byte of a five-byte burst
    for (int i = 0; i < 4; i++) write_byte(8'hD0 + 8'(i));
    s0 = sent_q.size();
    len_in = 5'd5; cfg_mode = 2'd0; cfg_ratio = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sent_q.size() < s0 + 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_wait_timeout", cyc < 500, 1'b1);
    check("cs_before_rst", cs_n, 1'b0);
    check("valid_before_rst", ctl_tx_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_cs_n", cs_n, 1'b1);
    check("rst_async_valid", ctl_tx_valid, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tx_q.delete(); rx_q.delete(); last_popped = 8'h00;
    @(negedge clk);
    check("post_rst_tx_full", tx_full, 1'b0);
    check("post_rst_rx_empty", rx_empty, 1'b1);
    check("post_rst_rx_data", rx_data, 8'd0);
    check("post_rst_cs_n", cs_n, 1'b1);
    $display("reset mid-burst done");
    write_byte(8'h5A); write_byte(8'h6B);
    run_burst(3, 2'd0, 8'd0, 1'b0);      // only two bytes remain after reset
    run_burst(2, 2'd0, 8'd0, 1'b0);
    repeat (3) pop_rx();

    // randomized traffic against the queue model
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(0, 8);
      for (int i = 0; i < nw; i++) begin
        b = 8'($urandom);
        write_byte(b);
      end
      run_burst($urandom_range(0, 18), 2'($urandom), 8'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)));
      np = $urandom_range(0, rx_q.size() + 1);
      for (int i = 0; i < np; i++) pop_rx();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
